multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Multi-cycle successor to the single-cycle MIPS-31 control decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Handshakes with instruction and data memories that may take several cycles.
- Emits per-state, one-cycle write-enable pulses in place of clock-gated writes; sits between the instruction decoder, datapath muxes, ALU, RF, PC and memories.

Parameters:
- TYPE_W, 31: width of one-hot instruction_type vector.
- TIMEOUT_CYCLES, 16: memory-wait limit, used only with BUS_TIMEOUT_EN; minimum 2.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): timeout counter width.

Ports:
- clk input 1: rising-edge clock.
- rst input 1: asynchronous, active-high reset.
- im_rdata input 32: instruction word from IM.
- im_ack input 1: IM data valid this cycle.
- instruction_type input TYPE_W: one-hot decode of instr_reg, from the external decoder.
  - Bit numbering: 0 add, 1 addu, 2 sub, 3 subu, 4 and, 5 or, 6 xor, 7 nor, 8 slt, 9 sltu, 10 sll, 11 srl, 12 sra, 13 sllv, 14 srlv, 15 srav, 16 jr, 17 addi, 18 addiu, 19 andi, 20 ori, 21 xori, 22 lui, 23 lw, 24 sw, 25 beq, 26 bne, 27 slti, 28 sltiu, 29 j, 30 jal.
- z input 1: ALU zero flag.
- dm_ack input 1: DM access complete.
- im_req output 1: IM read request.
- instr_reg output 32: latched instruction.
- pc_we output 1: one-cycle PC update pulse.
- pc_sel output 2: 00 pc+4, 01 branch target, 10 j/jal target, 11 rs (jr).
- rf_we output 1: one-cycle RF write pulse.
- rf_wsel output 2: 00 rd, 01 rt, 10 r31.
- rf_dsel output 2: 00 ALU, 01 DM, 10 pc+4.
- alu_asel output 1: 1 selects shamt (sll/srl/sra).
- alu_bsel output 2: 00 rt, 01 sign-ext imm, 10 zero-ext imm.
- aluc output 4: ALU opcode.
- dm_cs, dm_we, dm_re output 1 each: DM strobes.
- state output 3: current state, for debug.
- bus_err output 1: sticky error flag; constant 0 without BUS_TIMEOUT_EN.

Behaviour:
- Reset (async, rst=1): state=FETCH (0), instr_reg=0, all enables/strobes 0, all selects 0, timeout counter 0, bus_err 0.
- State encoding: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, ERROR 5.
- FETCH: im_req=1. On im_ack, instr_reg<=im_rdata and go to DECODE; otherwise stay.
- DECODE: 1 cycle; instruction_type is stable from here on. Go to EXEC.
- EXEC: 1 cycle; aluc, alu_asel and alu_bsel are valid.
  - beq/bne: pc_sel=01 if (beq&z)|(bne&~z), else 00; pc_we=1; go to FETCH.
  - j, jr: pc_sel 10 or 11; pc_we=1; go to FETCH.
  - lw/sw: go to MEM.
  - All others (incl. jal): go to WB.
- MEM: dm_cs=1, plus dm_re=lw or dm_we=sw, held until dm_ack.
  - On dm_ack, sw: pc_we=1, pc_sel=00, go to FETCH.
  - On dm_ack, lw: go to WB.
- WB: 1 cycle; rf_we=1 and pc_we=1.
  - pc_sel=10 for jal, else 00.
  - rf_wsel: 10 for jal; 01 for I-type ALU ops and lw; 00 otherwise.
  - rf_dsel: 01 for lw, 10 for jal, 00 otherwise. Go to FETCH.
- Latencies: R-type/I-type = 4 cycles + IM wait; lw = 5 + both waits; sw = 4 + both waits; branch/j/jr = 3 + IM wait.
- aluc mapping (held through MEM/WB):
  - add/addi 0010, addu/addiu/lw/sw 0000, sub 0011, subu/beq/bne 0001.
  - and/andi 0100, or/ori 0101, xor/xori 0110, nor 0111.
  - slt/slti 1011, sltu/sltiu 1010, lui 1000.
  - sll/sllv 1110, srl/srlv 1101, sra/srav 1100.
- alu_bsel: 01 for addi/addiu/slti/sltiu/lw/sw; 10 for andi/ori/xori/lui.
- Control outputs are combinational from state and the registered instr_reg/type; no output depends on im_ack/dm_ack except the state transitions. Acks arriving outside FETCH/MEM are ignored.
- instruction_type all-zero or multi-hot: treated as NOP through WB with rf_we=0 and pc_we=1.
- Async reset mid-MEM: strobes drop immediately and the in-flight instruction is discarded.

Optional Feature:
- Macro BUS_TIMEOUT_EN.
- When defined: a counter clears on entry to FETCH/MEM and increments each waiting cycle. If TIMEOUT_CYCLES is reached without an ack, go to ERROR. ERROR holds all strobes/enables at 0 with bus_err=1 until rst.
- When undefined: FETCH/MEM wait indefinitely, no counter logic, bus_err tied 0.

Test Plan:
- Reset asserted mid-MEM of sw with dm_we=1 -> dm_we, dm_cs drop in the same cycle; after release, state=0, im_req=1.
- addu, im_ack on first cycle -> states 0,1,2,4; aluc=0000; rf_we and pc_we each high exactly 1 cycle in WB; rf_wsel=00.
- lw with dm_ack delayed 3 cycles -> dm_re=1 for 3 cycles; then WB with rf_dsel=01, rf_wsel=01, aluc=0000, alu_bsel=01.
- beq, z=1 then bne, z=1 -> first: pc_we in EXEC with pc_sel=01, no WB; second: pc_sel=00.
- jal -> WB with rf_wsel=10, rf_dsel=10, pc_sel=10; jr -> EXEC exit with pc_sel=11, rf_we never high.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, im_ack held 0 -> state=5 after 4 waiting cycles, bus_err=1 and sticky until rst.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS-31 control FSM: FETCH/DECODE/EXEC/MEM/WB with IM/DM handshakes.
// Define BUS_TIMEOUT_EN to add a memory-wait timeout that parks the FSM in ERROR.
module multicycle_control_fsm #(
    parameter int TYPE_W         = 31,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       im_rdata,
    input  logic              im_ack,
    input  logic [TYPE_W-1:0] instruction_type,
    input  logic              z,
    input  logic              dm_ack,
    output logic              im_req,
    output logic [31:0]       instr_reg,
    output logic              pc_we,
    output logic [1:0]        pc_sel,
    output logic              rf_we,
    output logic [1:0]        rf_wsel,
    output logic [1:0]        rf_dsel,
    output logic              alu_asel,
    output logic [1:0]        alu_bsel,
    output logic [3:0]        aluc,
    output logic              dm_cs,
    output logic              dm_we,
    output logic              dm_re,
    output logic [2:0]        state,
    output logic              bus_err
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [TYPE_W-1:0] op;
    logic              one_hot, is_branch, is_itype, wait_expired;
    logic [3:0]        aluc_dec;
    logic [1:0]        bsel_dec;
    logic              shamt_dec;

    // Zero-hot or multi-hot decodes collapse to an all-zero op, which runs as a NOP.
    assign one_hot   = (instruction_type != '0) &&
                       ((instruction_type & (instruction_type - TYPE_W'(1))) == '0);
    assign op        = one_hot ? instruction_type : '0;
    assign is_branch = op[25] | op[26];
    assign is_itype  = op[17] | op[18] | op[19] | op[20] | op[21] | op[22] | op[27] | op[28];
    assign shamt_dec = op[10] | op[11] | op[12];
    assign state     = state_q;

    always_comb begin
        aluc_dec = 4'b0000;
        if (op[0] | op[17])                aluc_dec = 4'b0010;
        if (op[2])                         aluc_dec = 4'b0011;
        if (op[3] | op[25] | op[26])       aluc_dec = 4'b0001;
        if (op[4] | op[19])                aluc_dec = 4'b0100;
        if (op[5] | op[20])                aluc_dec = 4'b0101;
        if (op[6] | op[21])                aluc_dec = 4'b0110;
        if (op[7])                         aluc_dec = 4'b0111;
        if (op[8] | op[27])                aluc_dec = 4'b1011;
        if (op[9] | op[28])                aluc_dec = 4'b1010;
        if (op[22])                        aluc_dec = 4'b1000;
        if (op[10] | op[13])               aluc_dec = 4'b1110;
        if (op[11] | op[14])               aluc_dec = 4'b1101;
        if (op[12] | op[15])               aluc_dec = 4'b1100;
        bsel_dec = 2'b00;
        if (op[17] | op[18] | op[27] | op[28] | op[23] | op[24]) bsel_dec = 2'b01;
        if (op[19] | op[20] | op[21] | op[22])                  bsel_dec = 2'b10;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instr_reg <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH && im_ack)
                instr_reg <= im_rdata;
        end
    end

`ifdef BUS_TIMEOUT_EN
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (state_d != state_q)
            wait_cnt <= '0;
        else if (state_q == S_FETCH || state_q == S_MEM)
            wait_cnt <= wait_cnt + CNT_W'(1);
    end

    assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_err      = (state_q == S_ERROR);
`else
    logic [CNT_W-1:0] unused_timeout;
    assign unused_timeout = CNT_W'(TIMEOUT_CYCLES);
    assign wait_expired   = 1'b0;
    assign bus_err        = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        im_req   = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 2'b00;
        rf_we    = 1'b0;
        rf_wsel  = 2'b00;
        rf_dsel  = 2'b00;
        alu_asel = 1'b0;
        alu_bsel = 2'b00;
        aluc     = 4'b0000;
        dm_cs    = 1'b0;
        dm_we    = 1'b0;
        dm_re    = 1'b0;
        // ALU controls stay valid from EXEC through WB
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            aluc     = aluc_dec;
            alu_asel = shamt_dec;
            alu_bsel = bsel_dec;
        end
        case (state_q)
            S_FETCH: begin
                im_req = 1'b1;
                if (im_ack)
                    state_d = S_DECODE;
                else if (wait_expired)
                    state_d = S_ERROR;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (is_branch) begin
                    pc_we   = 1'b1;
                    pc_sel  = ((op[25] & z) | (op[26] & ~z)) ? 2'b01 : 2'b00;
                    state_d = S_FETCH;
                end else if (op[29]) begin
                    pc_we   = 1'b1;
                    pc_sel  = 2'b10;
                    state_d = S_FETCH;
                end else if (op[16]) begin
                    pc_we   = 1'b1;
                    pc_sel  = 2'b11;
                    state_d = S_FETCH;
                end else if (op[23] | op[24]) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dm_cs = 1'b1;
                dm_re = op[23];
                dm_we = op[24];
                if (dm_ack) begin
                    if (op[24]) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_expired) begin
                    state_d = S_ERROR;
                end
            end
            S_WB: begin
                pc_we   = 1'b1;
                rf_we   = one_hot;
                pc_sel  = op[30] ? 2'b10 : 2'b00;
                rf_wsel = op[30] ? 2'b10 : ((is_itype | op[23]) ? 2'b01 : 2'b00);
                rf_dsel = op[23] ? 2'b01 : (op[30] ? 2'b10 : 2'b00);
                state_d = S_FETCH;
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_FETCH;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: a per-instruction cycle trace is built
// from the instruction-class rules and compared against the DUT every cycle.
module tb_multicycle_control_fsm;
    localparam int TYPE_W = 31;
`ifdef BUS_TIMEOUT_EN
    localparam int TO_CYC = 4;
`else
    localparam int TO_CYC = 16;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       im_rdata = '0;
    logic              im_ack = 1'b0;
    logic [TYPE_W-1:0] instruction_type = '0;
    logic              z = 1'b0;
    logic              dm_ack = 1'b0;
    logic              im_req, pc_we, rf_we, alu_asel, dm_cs, dm_we, dm_re, bus_err;
    logic [31:0]       instr_reg;
    logic [1:0]        pc_sel, rf_wsel, rf_dsel, alu_bsel;
    logic [3:0]        aluc;
    logic [2:0]        state;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.TYPE_W(TYPE_W), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk(clk), .rst(rst), .im_rdata(im_rdata), .im_ack(im_ack),
        .instruction_type(instruction_type), .z(z), .dm_ack(dm_ack),
        .im_req(im_req), .instr_reg(instr_reg), .pc_we(pc_we), .pc_sel(pc_sel),
        .rf_we(rf_we), .rf_wsel(rf_wsel), .rf_dsel(rf_dsel), .alu_asel(alu_asel),
        .alu_bsel(alu_bsel), .aluc(aluc), .dm_cs(dm_cs), .dm_we(dm_we), .dm_re(dm_re),
        .state(state), .bus_err(bus_err)
    );

    typedef struct {
        logic [2:0] st;
        bit         im_req, pc_we, rf_we, dm_cs, dm_we, dm_re, alu_chk, im_ack, dm_ack;
        logic [1:0] pc_sel, rf_wsel, rf_dsel;
    } cyc_t;

    // Index = instruction_type bit; jr/j/jal have no defined ALU op and are not checked.
    logic [3:0] aluc_tab [31] = '{
        4'b0010, 4'b0000, 4'b0011, 4'b0001, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
        4'b1011, 4'b1010, 4'b1110, 4'b1101, 4'b1100, 4'b1110, 4'b1101, 4'b1100,
        4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0101, 4'b0110, 4'b1000, 4'b0000,
        4'b0000, 4'b0001, 4'b0001, 4'b1011, 4'b1010, 4'b0000, 4'b0000};

    cyc_t        tr[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_ir = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic cyc_t blank(input logic [2:0] st);
        cyc_t c;
        c.st = st; c.im_req = 0; c.pc_we = 0; c.rf_we = 0; c.dm_cs = 0; c.dm_we = 0;
        c.dm_re = 0; c.alu_chk = 0; c.im_ack = 0; c.dm_ack = 0;
        c.pc_sel = 2'b00; c.rf_wsel = 2'b00; c.rf_dsel = 2'b00;
        return c;
    endfunction

    // k: 0..30 one-hot bit, 31 all-zero decode, 32 multi-hot decode.
    function automatic void build(input int k, input int n_im, input int n_dm, input bit zz);
        cyc_t c;
        bit nop = (k > 30);
        bit lw = (k == 23);
        bit sw = (k == 24);
        bit jal = (k == 30);
        bit itype = (k >= 17 && k <= 22) || k == 27 || k == 28;
        tr.delete();
        for (int i = 0; i <= n_im; i++) begin
            c = blank(3'd0); c.im_req = 1; c.im_ack = (i == n_im); tr.push_back(c);
        end
        tr.push_back(blank(3'd1));
        c = blank(3'd2); c.alu_chk = 1;
        if (k == 25 || k == 26 || k == 29 || k == 16) begin
            c.pc_we = 1;
            if (k == 29) c.pc_sel = 2'b10;
            else if (k == 16) c.pc_sel = 2'b11;
            else if ((k == 25 && zz) || (k == 26 && !zz)) c.pc_sel = 2'b01;
            tr.push_back(c);
            return;
        end
        tr.push_back(c);
        if (lw || sw) begin
            for (int i = 0; i <= n_dm; i++) begin
                c = blank(3'd3); c.alu_chk = 1; c.dm_cs = 1; c.dm_re = lw; c.dm_we = sw;
                c.dm_ack = (i == n_dm);
                c.pc_we = sw && (i == n_dm);
                tr.push_back(c);
            end
            if (sw) return;
        end
        c = blank(3'd4); c.alu_chk = 1; c.pc_we = 1;
        if (!nop) begin
            c.rf_we   = 1;
            c.pc_sel  = jal ? 2'b10 : 2'b00;
            c.rf_wsel = jal ? 2'b10 : ((itype || lw) ? 2'b01 : 2'b00);
            c.rf_dsel = lw ? 2'b01 : (jal ? 2'b10 : 2'b00);
        end
        tr.push_back(c);
    endfunction

    task automatic run(input int k, input int n_im, input int n_dm, input bit zz,
                       input bit abort_mem, output int ncyc, output int nrf);
        logic [31:0]       word;
        logic [TYPE_W-1:0] ty;
        int                a, b;
        build(k, n_im, n_dm, zz);
        word = $urandom;
        ty   = '0;
        if (k <= 30) ty[k] = 1'b1;
        else if (k == 32) begin
            a = $urandom_range(0, 30);
            b = (a + 1 + $urandom_range(0, 29)) % 31;
            ty[a] = 1'b1; ty[b] = 1'b1;
        end
        instruction_type = ty; im_rdata = word; z = zz;
        ncyc = 0; nrf = 0;
        foreach (tr[i]) begin
            im_ack = (tr[i].st == 3'd0) ? tr[i].im_ack : 1'($urandom_range(0, 1));
            dm_ack = (tr[i].st == 3'd3) ? tr[i].dm_ack : 1'($urandom_range(0, 1));
            @(negedge clk);
            ncyc++;
            if (rf_we) nrf++;
            chk("state", state, tr[i].st);
            chk("im_req", im_req, tr[i].im_req);
            chk("pc_we", pc_we, tr[i].pc_we);
            chk("rf_we", rf_we, tr[i].rf_we);
            chk("dm_cs", dm_cs, tr[i].dm_cs);
            chk("dm_we", dm_we, tr[i].dm_we);
            chk("dm_re", dm_re, tr[i].dm_re);
            chk("bus_err", bus_err, 0);
            chk("instr_reg", instr_reg, exp_ir);
            if (tr[i].pc_we) chk("pc_sel", pc_sel, tr[i].pc_sel);
            if (tr[i].rf_we) begin
                chk("rf_wsel", rf_wsel, tr[i].rf_wsel);
                chk("rf_dsel", rf_dsel, tr[i].rf_dsel);
            end
            if (tr[i].alu_chk && k <= 30) begin
                chk("alu_asel", alu_asel, (k >= 10 && k <= 12));
                chk("alu_bsel", alu_bsel,
                    (k == 17 || k == 18 || k == 27 || k == 28 || k == 23 || k == 24) ? 2'b01 :
                    (k >= 19 && k <= 22) ? 2'b10 : 2'b00);
                if (k != 16 && k != 29 && k != 30) chk("aluc", aluc, aluc_tab[k]);
            end
            if (abort_mem && tr[i].st == 3'd3) begin
                #2 rst = 1'b1;
                #1;
                chk("abort_dm_we", dm_we, 0);
                chk("abort_dm_cs", dm_cs, 0);
                chk("abort_state", state, 0);
                @(posedge clk);
                #1 rst = 1'b0; exp_ir = '0; im_ack = 1'b0; dm_ack = 1'b0;
                #1;
                chk("post_abort_state", state, 0);
                chk("post_abort_im_req", im_req, 1);
                chk("post_abort_ir", instr_reg, 0);
                return;
            end
            @(posedge clk);
            #1;
            if (tr[i].st == 3'd0 && tr[i].im_ack) exp_ir = word;
        end
    endtask

    initial begin
        int n, r;
        #3;
        chk("rst_state", state, 0);
        chk("rst_pc_we", pc_we, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_dm_cs", dm_cs, 0);
        chk("rst_selects", {pc_sel, rf_wsel, rf_dsel, alu_bsel, alu_asel, aluc}, 0);
        chk("rst_ir", instr_reg, 0);
        chk("rst_bus_err", bus_err, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        run(1, 0, 0, 0, 0, n, r);  chk("addu_cycles", n, 4); chk("addu_rf_pulses", r, 1);
        run(23, 0, 2, 0, 0, n, r); chk("lw_cycles", n, 7);   chk("lw_rf_pulses", r, 1);
        run(25, 0, 0, 1, 0, n, r); chk("beq_cycles", n, 3);  chk("beq_rf_pulses", r, 0);
        run(26, 0, 0, 1, 0, n, r); chk("bne_cycles", n, 3);
        run(30, 1, 0, 0, 0, n, r); chk("jal_cycles", n, 5);  chk("jal_rf_pulses", r, 1);
        run(16, 0, 0, 0, 0, n, r); chk("jr_cycles", n, 3);   chk("jr_rf_pulses", r, 0);
        run(24, 0, 1, 0, 0, n, r); chk("sw_cycles", n, 5);   chk("sw_rf_pulses", r, 0);
        run(31, 0, 0, 0, 0, n, r); chk("nop_cycles", n, 4);  chk("nop_rf_pulses", r, 0);
        run(24, 0, 5, 0, 1, n, r);

        for (int i = 0; i < 300; i++)
            run($urandom_range(0, 32), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 0, n, r);

`ifdef BUS_TIMEOUT_EN
        im_ack = 1'b0; dm_ack = 1'b0;
        for (int i = 0; i < TO_CYC; i++) begin
            @(negedge clk);
            chk("to_wait_state", state, 0);
            chk("to_wait_err", bus_err, 0);
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("to_err_state", state, 5);
            chk("to_err_flag", bus_err, 1);
            chk("to_err_strobes", {im_req, pc_we, rf_we, dm_cs, dm_we, dm_re}, 0);
            im_ack = 1'b1; dm_ack = 1'b1;
        end
        rst = 1'b1;
        #1;
        chk("to_rst_err", bus_err, 0);
        chk("to_rst_state", state, 0);
        @(posedge clk);
        #1 rst = 1'b0; im_ack = 1'b0; dm_ack = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
